// File: rtl/dmem_access_ctrl_if.sv
// Request/response bundle between the execute stage and the memory-stage
// controller.
//   master : execute side. It drives req_* and receives req_ready, resp_* and err.
//   slave  : controller side.
interface dmem_access_ctrl_if #(parameter int WIDTH = 32);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [1:0]       req_mode;
  logic             req_signed;
  logic [4:0]       req_rd;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic [4:0]       resp_rd;
  logic             err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_mode, req_signed, req_rd,
    input  req_ready, resp_valid, resp_data, resp_rd, err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_mode, req_signed, req_rd,
    output req_ready, resp_valid, resp_data, resp_rd, err
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Memory-stage controller in front of the data memory.
// It takes one load or store at a time and checks its alignment. It then drives
// the memory's edge-triggered wr/rd strobes and owns the shared data bus.
// Load data is sign- or zero-extended before it goes back to writeback.
// Ports:
//   i_clk, i_rst : clock and synchronous active-high reset
//   bus          : request/response bundle (slave side)
//   o_dm_add     : memory address
//   o_dm_mode    : memory access size
//   io_dm_data   : shared data bus. It is driven only during a store.
//   o_dm_wr      : memory write strobe
//   o_dm_rd      : memory read strobe
//   i_dm_rd_st   : memory read status
module dmem_access_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  dmem_access_ctrl_if.slave bus,
  output logic [WIDTH-1:0] o_dm_add,
  inout  wire  [WIDTH-1:0] io_dm_data,
  output logic             o_dm_wr,
  output logic             o_dm_rd,
  input  logic             i_dm_rd_st,
  output logic [1:0]       o_dm_mode
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, WAIT, DONE, ERR
  } state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_add, r_wdata, r_resp_data, w_ext;
  logic [1:0]       r_mode;
  logic             r_we, r_signed;
  logic [4:0]       r_rd, r_resp_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_misalign, w_accept, w_drv, w_last_wait;

  assign w_accept    = (r_state == IDLE) && bus.req_valid;
  assign w_last_wait = (r_cnt == CW'(TIMEOUT - 1));
  assign w_misalign  = (bus.req_mode == 2'd3) ||
                       ((bus.req_mode == 2'd0) && (bus.req_addr[1:0] != 2'b00)) ||
                       ((bus.req_mode == 2'd1) && bus.req_addr[0]);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.req_valid) w_next = w_misalign ? ERR : SETUP;
      SETUP:   w_next = STROBE;
      STROBE:  w_next = r_we ? HOLD : WAIT;
      HOLD:    w_next = IDLE;
      WAIT: begin
        if (i_dm_rd_st)       w_next = DONE;
        else if (w_last_wait) w_next = ERR;
      end
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Memory data arrives right-justified. The access size and the signed flag
  // are taken from the latched request, not from the live request inputs.
  always_comb begin
    w_ext = io_dm_data;
    case (r_mode)
      2'd1: w_ext = r_signed ? {{(WIDTH-16){io_dm_data[15]}}, io_dm_data[15:0]}
                             : {{(WIDTH-16){1'b0}}, io_dm_data[15:0]};
      2'd2: w_ext = r_signed ? {{(WIDTH-8){io_dm_data[7]}}, io_dm_data[7:0]}
                             : {{(WIDTH-8){1'b0}}, io_dm_data[7:0]};
      default: w_ext = io_dm_data;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_add       <= '0;
      r_wdata     <= '0;
      r_mode      <= 2'd0;
      r_we        <= 1'b0;
      r_signed    <= 1'b0;
      r_rd        <= 5'd0;
      r_resp_data <= '0;
      r_resp_rd   <= 5'd0;
      r_cnt       <= '0;
    end else begin
      if (w_accept) begin
        r_add    <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
        r_mode   <= bus.req_mode;
        r_we     <= bus.req_we;
        r_signed <= bus.req_signed;
        r_rd     <= bus.req_rd;
      end
      if (r_state == STROBE) r_cnt <= '0;
      else if (r_state == WAIT && !i_dm_rd_st) r_cnt <= r_cnt + 1'b1;
      if (r_state == WAIT && i_dm_rd_st) begin
        r_resp_data <= w_ext;
        r_resp_rd   <= r_rd;
      end
    end
  end

  // Strobes are decoded from the registered state, so each strobe is high for
  // exactly one cycle. Address, mode and data all come from registers that
  // only load in IDLE, which keeps them stable around every strobe.
  assign w_drv      = r_we && (r_state == SETUP || r_state == STROBE || r_state == HOLD);
  assign io_dm_data = w_drv ? r_wdata : {WIDTH{1'bz}};
  assign o_dm_wr    = (r_state == STROBE) && r_we;
  assign o_dm_rd    = (r_state == STROBE) && !r_we;
  assign o_dm_add   = r_add;
  assign o_dm_mode  = r_mode;

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == DONE);
  assign bus.err        = (r_state == ERR);
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_rd    = r_resp_rd;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dm_add;
  wire  [31:0] dm_data;
  logic        dm_wr, dm_rd, dm_rd_st;
  logic [1:0]  dm_mode;
  int checks = 0, failures = 0;

  dmem_access_ctrl_if #(.WIDTH(32)) bus ();

  dmem_access_ctrl #(.WIDTH(32), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus), .o_dm_add(dm_add), .io_dm_data(dm_data),
    .o_dm_wr(dm_wr), .o_dm_rd(dm_rd), .i_dm_rd_st(dm_rd_st), .o_dm_mode(dm_mode)
  );

  always #5 clk = ~clk;

  // Memory model: big-endian bytes, right-justified reads, and edge-triggered strobes.
  logic [7:0]  mem [256];
  logic        mem_drv = 1'b0, mem_dead = 1'b0;
  logic [31:0] mem_q = '0;
  assign dm_data = mem_drv ? mem_q : 32'hzzzz_zzzz;
  initial begin
    dm_rd_st = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  end

  always @(posedge dm_wr) begin
    case (dm_mode)
      2'd0: begin
        mem[dm_add[7:0]]        = dm_data[31:24];
        mem[dm_add[7:0] + 8'd1] = dm_data[23:16];
        mem[dm_add[7:0] + 8'd2] = dm_data[15:8];
        mem[dm_add[7:0] + 8'd3] = dm_data[7:0];
      end
      2'd1: begin
        mem[dm_add[7:0]]        = dm_data[15:8];
        mem[dm_add[7:0] + 8'd1] = dm_data[7:0];
      end
      default: mem[dm_add[7:0]] = dm_data[7:0];
    endcase
  end

  always @(posedge dm_rd) begin
    if (!mem_dead) begin
      case (dm_mode)
        2'd0: mem_q = {mem[dm_add[7:0]], mem[dm_add[7:0] + 8'd1],
                       mem[dm_add[7:0] + 8'd2], mem[dm_add[7:0] + 8'd3]};
        2'd1: mem_q = {16'h0, mem[dm_add[7:0]], mem[dm_add[7:0] + 8'd1]};
        default: mem_q = {24'h0, mem[dm_add[7:0]]};
      endcase
      mem_drv  = 1'b1;
      dm_rd_st = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      mem_drv  = 1'b0;
      dm_rd_st = 1'b0;
    end
  end

  // Per-cycle samples. Index k is the k-th cycle after the accepting edge.
  logic        s_wr[16], s_rd[16], s_drv[16], s_rv[16], s_err[16], s_rdy[16];
  logic [31:0] s_add[16], s_bus[16], s_data[16];
  logic [4:0]  s_tag[16];

  task automatic record(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      s_wr[k]  = dm_wr;          s_rd[k]  = dm_rd;
      s_drv[k] = dut.w_drv;      s_rv[k]  = bus.resp_valid;
      s_err[k] = bus.err;        s_rdy[k] = bus.req_ready;
      s_add[k] = dm_add;         s_bus[k] = dm_data;
      s_data[k] = bus.resp_data; s_tag[k] = bus.resp_rd;
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] m, input logic sg, input logic [4:0] rd);
    @(posedge clk); #1;
    bus.req_we = we; bus.req_addr = a; bus.req_wdata = wd;
    bus.req_mode = m; bus.req_signed = sg; bus.req_rd = rd; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_mode = 2'd0; bus.req_signed = 1'b0; bus.req_rd = 5'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.err, dm_wr, dm_rd, dut.w_drv} !== 6'b100000) begin
      failures++; $display("FAIL reset_ctrl got %b exp 100000",
        {bus.req_ready, bus.resp_valid, bus.err, dm_wr, dm_rd, dut.w_drv});
    end
    checks++;
    if ({dm_add, dm_mode, bus.resp_data, bus.resp_rd} !== 71'd0) begin
      failures++; $display("FAIL reset_regs add=%h mode=%0d data=%h rd=%0d exp all 0",
        dm_add, dm_mode, bus.resp_data, bus.resp_rd);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_word();
    issue(1'b1, 32'h10, 32'hDEADBEEF, 2'd0, 1'b0, 5'd0);
    record(4);
    checks++;
    if ({s_wr[1], s_wr[2], s_wr[3], s_wr[4]} !== 4'b0100) begin
      failures++; $display("FAIL st_wr_pulse got %b exp 0100", {s_wr[1], s_wr[2], s_wr[3], s_wr[4]});
    end
    checks++;
    if ({s_drv[1], s_drv[2], s_drv[3], s_drv[4]} !== 4'b1110) begin
      failures++; $display("FAIL st_bus_drive got %b exp 1110", {s_drv[1], s_drv[2], s_drv[3], s_drv[4]});
    end
    checks++;
    if (s_bus[2] !== 32'hDEADBEEF || s_add[1] !== 32'h10 || s_add[3] !== 32'h10) begin
      failures++; $display("FAIL st_bus_addr data=%h add=%h exp DEADBEEF/10", s_bus[2], s_add[1]);
    end
    checks++;
    if ({s_rdy[1], s_rdy[3], s_rdy[4]} !== 3'b001) begin
      failures++; $display("FAIL st_ready got %b exp 001", {s_rdy[1], s_rdy[3], s_rdy[4]});
    end
    checks++;
    if ({mem[16], mem[17], mem[18], mem[19]} !== 32'hDEADBEEF) begin
      failures++; $display("FAIL st_mem got %h exp DEADBEEF", {mem[16], mem[17], mem[18], mem[19]});
    end
    issue(1'b0, 32'h10, 32'h0, 2'd0, 1'b0, 5'd5);
    record(4);
    checks++;
    if ({s_rd[1], s_rd[2], s_rd[3], s_drv[2]} !== 4'b0100) begin
      failures++; $display("FAIL ld_rd_pulse got %b exp 0100", {s_rd[1], s_rd[2], s_rd[3], s_drv[2]});
    end
    checks++;
    if ({s_rv[3], s_rv[4]} !== 2'b01 || s_data[4] !== 32'hDEADBEEF || s_tag[4] !== 5'd5) begin
      failures++; $display("FAIL ld_word rv=%b data=%h tag=%0d exp 01/DEADBEEF/5",
        {s_rv[3], s_rv[4]}, s_data[4], s_tag[4]);
    end
  endtask

  task automatic test_extend();
    logic [1:0]  m[4];
    logic        sg[4];
    logic [31:0] a[4], ex[4];
    m = '{2'd2, 2'd2, 2'd1, 2'd0};
    sg = '{1'b1, 1'b0, 1'b1, 1'b1};
    a = '{32'h13, 32'h13, 32'h12, 32'h10};
    ex = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFBE80, 32'hDEADBE80};
    issue(1'b1, 32'h13, 32'h12345680, 2'd2, 1'b0, 5'd0);
    record(4);
    checks++;
    if (mem[19] !== 8'h80 || mem[18] !== 8'hBE) begin
      failures++; $display("FAIL st_byte got %h%h exp BE80", mem[18], mem[19]);
    end
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, a[i], 32'h0, m[i], sg[i], 5'(i + 8));
      record(4);
      checks++;
      if (s_rv[4] !== 1'b1 || s_data[4] !== ex[i] || s_tag[4] !== 5'(i + 8)) begin
        failures++; $display("FAIL ld_ext%0d rv=%b data=%h tag=%0d exp 1/%h/%0d",
          i, s_rv[4], s_data[4], s_tag[4], ex[i], i + 8);
      end
    end
  endtask

  task automatic test_misaligned();
    logic        we[3];
    logic [31:0] a[3];
    logic [1:0]  m[3];
    we = '{1'b0, 1'b1, 1'b0};
    a = '{32'h11, 32'h02, 32'h00};
    m = '{2'd1, 2'd0, 2'd3};
    for (int i = 0; i < 3; i++) begin
      issue(we[i], a[i], 32'hFFFFFFFF, m[i], 1'b0, 5'd1);
      record(3);
      checks++;
      if ({s_err[1], s_err[2], s_rdy[1], s_rdy[2]} !== 4'b1001) begin
        failures++; $display("FAIL misalign%0d err/rdy got %b exp 1001",
          i, {s_err[1], s_err[2], s_rdy[1], s_rdy[2]});
      end
      checks++;
      if ({s_wr[1], s_wr[2], s_wr[3], s_rd[1], s_rd[2], s_rd[3], s_rv[1], s_rv[2], s_rv[3]} !== 9'b0) begin
        failures++; $display("FAIL misalign%0d_side got %b exp 0", i,
          {s_wr[1], s_wr[2], s_wr[3], s_rd[1], s_rd[2], s_rd[3], s_rv[1], s_rv[2], s_rv[3]});
      end
    end
  endtask

  task automatic test_timeout();
    logic any_rv;
    mem_dead = 1'b1;
    issue(1'b0, 32'h10, 32'h0, 2'd0, 1'b0, 5'd3);
    record(12);
    any_rv = 1'b0;
    for (int k = 1; k <= 12; k++) any_rv |= s_rv[k];
    checks++;
    if ({s_err[10], s_err[11], s_err[12], s_rdy[11], s_rdy[12], any_rv} !== 6'b010010) begin
      failures++; $display("FAIL timeout got %b exp 010010",
        {s_err[10], s_err[11], s_err[12], s_rdy[11], s_rdy[12], any_rv});
    end
    mem_dead = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 5'd4);
    record(4);
    checks++;
    if (s_rv[4] !== 1'b1 || s_data[4] !== 32'h000000DE || s_tag[4] !== 5'd4) begin
      failures++; $display("FAIL after_timeout rv=%b data=%h tag=%0d exp 1/000000DE/4",
        s_rv[4], s_data[4], s_tag[4]);
    end
  endtask

  task automatic test_reset_mid_op();
    issue(1'b1, 32'h40, 32'hA5A5A5A5, 2'd0, 1'b0, 5'd0);
    record(2);
    checks++;
    if (s_wr[2] !== 1'b1) begin
      failures++; $display("FAIL rst_pre_wr got %b exp 1", s_wr[2]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({dm_wr, dut.w_drv, bus.req_ready, bus.err, bus.resp_valid} !== 5'b00100 || dm_add !== 32'h0) begin
      failures++; $display("FAIL rst_mid got %b add=%h exp 00100/0",
        {dm_wr, dut.w_drv, bus.req_ready, bus.err, bus.resp_valid}, dm_add);
    end
    rst = 1'b0;
    record(3);
    checks++;
    if ({s_err[1], s_err[2], s_err[3], s_wr[1], s_wr[2], s_wr[3], s_rdy[3]} !== 7'b0000001) begin
      failures++; $display("FAIL rst_after got %b exp 0000001",
        {s_err[1], s_err[2], s_err[3], s_wr[1], s_wr[2], s_wr[3], s_rdy[3]});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a[3], ex[3];
    logic [1:0]  m[3];
    logic        acc, prev_str;
    logic [31:0] prev_add;
    int idx = 0, nresp = 0, last_acc = 0, cyc = 0;
    a = '{32'h10, 32'h13, 32'h12};
    m = '{2'd0, 2'd2, 2'd1};
    ex = '{32'hDEADBE80, 32'h00000080, 32'h0000BE80};
    @(posedge clk); #1;
    bus.req_we = 1'b0; bus.req_signed = 1'b0;
    bus.req_addr = a[0]; bus.req_mode = m[0]; bus.req_rd = 5'd20; bus.req_valid = 1'b1;
    prev_str = 1'b0;
    prev_add = dm_add;
    while (nresp < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      acc = bus.req_ready && bus.req_valid;
      if ((dm_wr || dm_rd) && (prev_str || dm_add !== prev_add)) begin
        checks++; failures++;
        $display("FAIL b2b_strobe cyc=%0d add=%h prev=%h exp stable single strobe", cyc, dm_add, prev_add);
      end
      if (bus.resp_valid) begin
        checks++;
        if (bus.resp_data !== ex[nresp] || bus.resp_rd !== 5'(20 + nresp)) begin
          failures++; $display("FAIL b2b_resp%0d data=%h tag=%0d exp %h/%0d",
            nresp, bus.resp_data, bus.resp_rd, ex[nresp], 20 + nresp);
        end
        nresp++;
      end
      prev_str = dm_wr || dm_rd;
      prev_add = dm_add;
      @(posedge clk); #1;
      if (acc) begin
        if (idx > 0) begin
          checks++;
          if (cyc - last_acc !== 5) begin
            failures++; $display("FAIL b2b_gap%0d got %0d exp 5", idx, cyc - last_acc);
          end
        end
        last_acc = cyc;
        idx++;
        if (idx == 3) bus.req_valid = 1'b0;
        else begin
          bus.req_addr = a[idx]; bus.req_mode = m[idx]; bus.req_rd = 5'(20 + idx);
        end
      end
    end
    checks++;
    if (nresp !== 3 || idx !== 3) begin
      failures++; $display("FAIL b2b_count resp=%0d acc=%0d exp 3/3", nresp, idx);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_extend();
    test_misaligned();
    test_timeout();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
